// File: rtl/branch_resolve_if.sv
// Bundles the EX-stage flag/branch inputs and the redirect, flush and statistics outputs
// of the branch resolution unit.
interface branch_resolve_if #(
  parameter int W     = 16,
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic             stall;
  logic [2:0]       br_op;
  logic             zero;
  logic             lt;
  logic             lte;
  logic [W-1:0]     br_target;
  logic             redirect;
  logic [W-1:0]     redirect_pc;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             ex_kill;
  logic             align_err;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output ex_valid, stall, br_op, zero, lt, lte, br_target,
    input  redirect, redirect_pc, flush_if_id, flush_id_ex, ex_kill,
           align_err, br_count, taken_count
  );

  modport slave (
    input  ex_valid, stall, br_op, zero, lt, lte, br_target,
    output redirect, redirect_pc, flush_if_id, flush_id_ex, ex_kill,
           align_err, br_count, taken_count
  );
endinterface

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: predict-not-taken, registered redirect and flush
// on a taken branch, misalignment pulse, and saturating branch statistics.
module branch_resolve #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.slave bus
);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             cond_taken;
  logic             sampled;
  logic             take;
  logic             aligned_take;
  logic [W-1:0]     pc_q;
  logic             align_q;
  logic [CNT_W-1:0] br_q;
  logic [CNT_W-1:0] taken_q;

  always_comb begin
    cond_taken = 1'b0;
    case (bus.br_op)
      3'b001:  cond_taken = bus.zero;
      3'b010:  cond_taken = !bus.zero;
      3'b011:  cond_taken = bus.lt;
      3'b100:  cond_taken = !bus.lt;
      3'b101:  cond_taken = bus.lte;
      3'b110:  cond_taken = !bus.lte;
      3'b111:  cond_taken = 1'b1;
      default: cond_taken = 1'b0;
    endcase
  end

  // Anything reaching EX while FLUSH is wrong-path, so only IDLE may sample.
  assign sampled      = (state_q == IDLE) && bus.ex_valid && !bus.stall && (bus.br_op != 3'b000);
  assign take         = sampled && cond_taken;
  assign aligned_take = take && !bus.br_target[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aligned_take) state_d = FLUSH;
      FLUSH:   if (!bus.stall)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      align_q <= 1'b0;
    end else begin
      align_q <= take && bus.br_target[0];
      if (aligned_take) pc_q <= bus.br_target;
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_q    <= '0;
      taken_q <= '0;
    end else begin
      if (sampled && (br_q != {CNT_W{1'b1}}))  br_q    <= br_q + 1'b1;
      if (take && (taken_q != {CNT_W{1'b1}})) taken_q <= taken_q + 1'b1;
    end
  end

  assign bus.redirect    = (state_q == FLUSH);
  assign bus.flush_if_id = (state_q == FLUSH);
  assign bus.flush_id_ex = (state_q == FLUSH);
  assign bus.ex_kill     = (state_q == FLUSH);
  assign bus.redirect_pc = pc_q;
  assign bus.align_err   = align_q;
  assign bus.br_count    = br_q;
  assign bus.taken_count = taken_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random traffic,
// compared every cycle against a signed-result reference model.
module tb_branch_resolve;

  localparam logic [2:0] OP_NONE = 3'b000, OP_BEQZ = 3'b001, OP_BNEZ = 3'b010,
                         OP_BLTZ = 3'b011, OP_BGEZ = 3'b100, OP_BLEZ = 3'b101,
                         OP_BGTZ = 3'b110, OP_JMP  = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               tb_valid  = 1'b0;
  logic               tb_stall  = 1'b0;
  logic [2:0]         tb_op     = 3'b000;
  logic signed [15:0] tb_res    = 16'sd1;
  logic [15:0]        tb_target = 16'h0000;

  int errors = 0;
  int checks = 0;

  bit m_busy  = 1'b0;
  int m_pc    = 0;
  bit m_align = 1'b0;
  int m_br    = 0;
  int m_taken = 0;
  int m_br_s    = 0;
  int m_taken_s = 0;

  branch_resolve_if #(.W(16), .CNT_W(16)) bus ();
  branch_resolve_if #(.W(16), .CNT_W(4))  bus_s ();

  assign bus.ex_valid    = tb_valid;
  assign bus.stall       = tb_stall;
  assign bus.br_op       = tb_op;
  assign bus.zero        = (tb_res == 0);
  assign bus.lt          = (tb_res < 0);
  assign bus.lte         = (tb_res <= 0);
  assign bus.br_target   = tb_target;
  assign bus_s.ex_valid  = tb_valid;
  assign bus_s.stall     = tb_stall;
  assign bus_s.br_op     = tb_op;
  assign bus_s.zero      = (tb_res == 0);
  assign bus_s.lt        = (tb_res < 0);
  assign bus_s.lte       = (tb_res <= 0);
  assign bus_s.br_target = tb_target;

  branch_resolve #(.W(16), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  branch_resolve #(.W(16), .CNT_W(4))  dut_s (.clk(clk), .rst(rst), .bus(bus_s.slave));

  // Branch outcome from the signed ALU result itself rather than from the flags.
  function automatic bit isTaken(input logic [2:0] op, input int res);
    case (op)
      OP_BEQZ: return res == 0;
      OP_BNEZ: return res != 0;
      OP_BLTZ: return res < 0;
      OP_BGEZ: return res >= 0;
      OP_BLEZ: return res <= 0;
      OP_BGTZ: return res > 0;
      OP_JMP:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_busy = 1'b0; m_pc = 0; m_align = 1'b0;
    m_br = 0; m_taken = 0; m_br_s = 0; m_taken_s = 0;
  endtask

  task automatic checkAll();
    checkOutput("redirect",    {31'd0, bus.redirect},    {31'd0, m_busy});
    checkOutput("flush_if_id", {31'd0, bus.flush_if_id}, {31'd0, m_busy});
    checkOutput("flush_id_ex", {31'd0, bus.flush_id_ex}, {31'd0, m_busy});
    checkOutput("ex_kill",     {31'd0, bus.ex_kill},     {31'd0, m_busy});
    checkOutput("redirect_pc", {16'd0, bus.redirect_pc}, m_pc);
    checkOutput("align_err",   {31'd0, bus.align_err},   {31'd0, m_align});
    checkOutput("br_count",    {16'd0, bus.br_count},    m_br);
    checkOutput("taken_count", {16'd0, bus.taken_count}, m_taken);
    checkOutput("br_count_sat",    {28'd0, bus_s.br_count},    m_br_s);
    checkOutput("taken_count_sat", {28'd0, bus_s.taken_count}, m_taken_s);
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic stepCycle();
    bit sampled, tk;
    @(posedge clk);
    if (!m_busy) begin
      sampled = tb_valid && !tb_stall && (tb_op != OP_NONE);
      tk      = sampled && isTaken(tb_op, int'(tb_res));
      if (sampled) begin
        m_br   = (m_br   < 65535) ? m_br + 1   : 65535;
        m_br_s = (m_br_s < 15)    ? m_br_s + 1 : 15;
      end
      if (tk) begin
        m_taken   = (m_taken   < 65535) ? m_taken + 1   : 65535;
        m_taken_s = (m_taken_s < 15)    ? m_taken_s + 1 : 15;
      end
      m_align = tk && tb_target[0];
      if (tk && !tb_target[0]) begin
        m_busy = 1'b1;
        m_pc   = int'(tb_target);
      end
    end else begin
      m_align = 1'b0;
      if (!tb_stall) m_busy = 1'b0;
    end
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input bit valid, input bit stall, input logic [2:0] op,
                               input int res, input logic [15:0] target);
    tb_valid  = valid;
    tb_stall  = stall;
    tb_op     = op;
    tb_res    = 16'(res);
    tb_target = target;
    stepCycle();
  endtask

  task automatic applyReset();
    tb_valid = 1'b0; tb_stall = 1'b0; tb_op = OP_NONE;
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r;
    applyReset();
    checkAll();

    // Taken BEQZ then idle
    applyStimulus(1, 0, OP_BEQZ, 0, 16'h0040);
    checkOutput("beqz_redirect", {31'd0, bus.redirect}, 32'd1);
    checkOutput("beqz_pc", {16'd0, bus.redirect_pc}, 32'h40);
    checkOutput("beqz_br", {16'd0, bus.br_count}, 32'd1);
    checkOutput("beqz_taken", {16'd0, bus.taken_count}, 32'd1);
    applyStimulus(0, 0, OP_NONE, 1, 16'h0000);
    checkOutput("beqz_n2_kill", {31'd0, bus.ex_kill}, 32'd0);

    // Not-taken BGTZ with zero result
    applyStimulus(1, 0, OP_BGTZ, 0, 16'h0200);
    checkOutput("bgtz_redirect", {31'd0, bus.redirect}, 32'd0);
    checkOutput("bgtz_br", {16'd0, bus.br_count}, 32'd2);
    checkOutput("bgtz_taken", {16'd0, bus.taken_count}, 32'd1);

    // Shadow JMP behind a taken BLTZ
    applyReset();
    applyStimulus(1, 0, OP_BLTZ, -7, 16'h0080);
    applyStimulus(1, 0, OP_JMP, 3, 16'h0100);
    checkOutput("shadow_redirect", {31'd0, bus.redirect}, 32'd0);
    checkOutput("shadow_pc", {16'd0, bus.redirect_pc}, 32'h80);
    checkOutput("shadow_br", {16'd0, bus.br_count}, 32'd1);
    applyStimulus(0, 0, OP_NONE, 1, 16'h0000);

    // Stall holding FLUSH for three extra cycles
    applyReset();
    applyStimulus(1, 0, OP_BNEZ, 5, 16'h0abc);
    applyStimulus(1, 1, OP_JMP, 0, 16'h0100);
    applyStimulus(1, 1, OP_JMP, 0, 16'h0100);
    applyStimulus(1, 1, OP_JMP, 0, 16'h0100);
    checkOutput("stall_n4_redirect", {31'd0, bus.redirect}, 32'd1);
    applyStimulus(0, 0, OP_NONE, 0, 16'h0000);
    checkOutput("stall_n5_redirect", {31'd0, bus.redirect}, 32'd0);
    checkOutput("stall_br", {16'd0, bus.br_count}, 32'd1);

    // Misaligned JMP
    applyStimulus(1, 0, OP_JMP, 9, 16'h0031);
    checkOutput("mis_align", {31'd0, bus.align_err}, 32'd1);
    checkOutput("mis_redirect", {31'd0, bus.redirect}, 32'd0);
    checkOutput("mis_taken", {16'd0, bus.taken_count}, 32'd2);
    applyStimulus(0, 0, OP_NONE, 0, 16'h0000);
    checkOutput("mis_align_n2", {31'd0, bus.align_err}, 32'd0);

    // Asynchronous reset in the middle of FLUSH
    applyStimulus(1, 0, OP_BGEZ, 4, 16'h1234);
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async_redirect", {31'd0, bus.redirect}, 32'd0);
    checkOutput("async_kill", {31'd0, bus.ex_kill}, 32'd0);
    checkOutput("async_pc", {16'd0, bus.redirect_pc}, 32'd0);
    checkOutput("async_br", {16'd0, bus.br_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Twenty taken branches into the 4-bit counters
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, OP_JMP, 0, 16'h0010);
      applyStimulus(0, 0, OP_NONE, 0, 16'h0000);
    end
    checkOutput("sat_br", {28'd0, bus_s.br_count}, 32'd15);
    checkOutput("sat_taken", {28'd0, bus_s.taken_count}, 32'd15);

    // Random traffic
    applyReset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       r = 0;
        1:       r = int'($urandom_range(1, 32767));
        default: r = -int'($urandom_range(1, 32768));
      endcase
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    3'($urandom_range(0, 7)), r, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
